// File: rtl/axle_count_point.sv
// axle_count_point: bidirectional bogey counter for one axle-counting point.
// Two raw wheel sensors (A side, B side) are synchronized and debounced. An
// FSM then follows the A/B occupancy pattern and counts complete passages in
// each direction.
// Ports:
//   clk        rising-edge clock
//   Reset      synchronous, active-high reset
//   sens_a/b   raw sensors (asynchronous, bouncy)
//   clear      synchronous zeroing of both counts
//   Count_a2b  saturating count of A->B passages
//   Count_b2a  saturating count of B->A passages
//   busy       FSM away from IDLE (registered)
//   fault      one-cycle pulse on timeout or ambiguous sequence

// Per-sensor 2-flop synchronizer plus debounce filter. The filtered level
// flips only after the synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle restarts the run.
module axle_count_point_filt #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_filt
);
  logic       r_s1, r_s2, r_filt;
  logic [7:0] r_run;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_run  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_run <= '0;
      end else if (r_run == 8'(DEBOUNCE_CYCLES - 1)) begin
        r_filt <= r_s2;
        r_run  <= '0;
      end else begin
        r_run <= r_run + 8'd1;
      end
    end
  end

  assign o_filt = r_filt;
endmodule

module axle_count_point #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int MAX_COUNT       = 15
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic       clear,
  output logic [3:0] Count_a2b,
  output logic [3:0] Count_b2a,
  output logic       busy,
  output logic       fault
);
  typedef enum logic [2:0] {IDLE, A1, AB, A2, B1, BA, B2, WAIT} state_t;

  state_t      r_state, w_state_nx;
  logic        w_fa, w_fb;
  logic        w_fault_nx, w_inc_a2b, w_inc_b2a, w_tmo_hit;
  logic [15:0] r_tmo;
  logic [3:0]  r_a2b, r_b2a;
  logic        r_busy, r_fault;

  axle_count_point_filt #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
    .clk(clk), .Reset(Reset), .i_raw(sens_a), .o_filt(w_fa));
  axle_count_point_filt #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
    .clk(clk), .Reset(Reset), .i_raw(sens_b), .o_filt(w_fb));

  // Only the tracking states are time-limited. WAIT just waits for the track
  // to clear, however long that takes.
  assign w_tmo_hit = (r_state != IDLE) && (r_state != WAIT) &&
                     (r_tmo == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nx = r_state;
    w_fault_nx = 1'b0;
    w_inc_a2b  = 1'b0;
    w_inc_b2a  = 1'b0;
    if (w_tmo_hit) begin
      w_state_nx = WAIT;
      w_fault_nx = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fa && w_fb) begin
            w_state_nx = WAIT;
            w_fault_nx = 1'b1;
          end else if (w_fa) begin
            w_state_nx = A1;
          end else if (w_fb) begin
            w_state_nx = B1;
          end
        end
        A1: begin
          if (w_fb)       w_state_nx = AB;
          else if (!w_fa) w_state_nx = IDLE;  // backed out, no count
        end
        AB: begin
          if (!w_fa && w_fb)      w_state_nx = A2;
          else if (w_fa && !w_fb) w_state_nx = A1;  // reversal
          else if (!w_fa && !w_fb) begin
            w_state_nx = WAIT;
            w_fault_nx = 1'b1;
          end
        end
        A2: begin
          if (!w_fb) begin
            w_state_nx = IDLE;
            w_inc_a2b  = 1'b1;
          end else if (w_fa) begin
            w_state_nx = AB;
          end
        end
        B1: begin
          if (w_fa)       w_state_nx = BA;
          else if (!w_fb) w_state_nx = IDLE;
        end
        BA: begin
          if (!w_fb && w_fa)      w_state_nx = B2;
          else if (w_fb && !w_fa) w_state_nx = B1;
          else if (!w_fa && !w_fb) begin
            w_state_nx = WAIT;
            w_fault_nx = 1'b1;
          end
        end
        B2: begin
          if (!w_fa) begin
            w_state_nx = IDLE;
            w_inc_b2a  = 1'b1;
          end else if (w_fb) begin
            w_state_nx = BA;
          end
        end
        WAIT: begin
          if (!w_fa && !w_fb) w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_tmo   <= '0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
      r_a2b   <= '0;
      r_b2a   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != IDLE);
      r_fault <= w_fault_nx;
      // Timer restarts on any state change and never runs in IDLE or WAIT.
      if ((w_state_nx != r_state) || (r_state == IDLE) || (r_state == WAIT))
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 16'd1;
      // clear wins over a coincident increment.
      if (clear) begin
        r_a2b <= '0;
        r_b2a <= '0;
      end else begin
        if (w_inc_a2b && (r_a2b != 4'(MAX_COUNT))) r_a2b <= r_a2b + 4'd1;
        if (w_inc_b2a && (r_b2a != 4'(MAX_COUNT))) r_b2a <= r_b2a + 4'd1;
      end
    end
  end

  assign Count_a2b = r_a2b;
  assign Count_b2a = r_b2a;
  assign busy      = r_busy;
  assign fault     = r_fault;
endmodule

// File: tb/tb_axle_count_point.sv
module tb_axle_count_point;
  localparam int DEB = 4;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       Reset, sens_a, sens_b, clear;
  logic [3:0] Count_a2b, Count_b2a;
  logic       busy, fault;

  int n_tests = 0;
  int n_fail  = 0;
  int fault_cnt = 0;
  int fault_dbl = 0;
  logic fault_prev = 1'b0;

  axle_count_point #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .MAX_COUNT(15)) dut (
    .clk(clk), .Reset(Reset), .sens_a(sens_a), .sens_b(sens_b), .clear(clear),
    .Count_a2b(Count_a2b), .Count_b2a(Count_b2a), .busy(busy), .fault(fault));

  always #5 clk = ~clk;

  // Count fault pulses and catch any two-cycle-wide pulse.
  always @(negedge clk) begin
    if (fault) fault_cnt++;
    if (fault && fault_prev) fault_dbl++;
    fault_prev = fault;
  end

  typedef struct {
    logic       a;
    logic       b;
    logic       clr;
    int         cyc;
    logic [3:0] e_a2b;
    logic [3:0] e_b2a;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; sens_a = 1'b0; sens_b = 1'b0; clear = 1'b0;
    step(3);
    Reset = 1'b0;
  endtask

  task automatic ab_bogey();
    sens_a = 1'b1; step(10);
    sens_b = 1'b1; step(10);
    sens_a = 1'b0; step(10);
    sens_b = 1'b0; step(10);
  endtask

  task automatic ba_bogey();
    sens_b = 1'b1; step(10);
    sens_a = 1'b1; step(10);
    sens_b = 1'b0; step(10);
    sens_a = 1'b0; step(10);
  endtask

  initial begin
    int f0;
    logic busy_seen;

    // a, b, clear, cycles, exp a2b, exp b2a, exp busy
    tbl.push_back('{1'b0, 1'b0, 1'b0,  5, 4'd0, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 4'd0, 4'd0, 1'b1}); // A1
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 4'd0, 4'd0, 1'b1}); // AB
    tbl.push_back('{1'b0, 1'b1, 1'b0, 10, 4'd0, 4'd0, 1'b1}); // A2
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 4'd1, 4'd0, 1'b0}); // counted
    tbl.push_back('{1'b0, 1'b1, 1'b0, 10, 4'd1, 4'd0, 1'b1}); // B1
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 4'd1, 4'd0, 1'b1}); // BA
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 4'd1, 4'd0, 1'b1}); // B2
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 4'd1, 4'd1, 1'b0}); // counted
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 4'd1, 4'd1, 1'b1}); // A1
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 4'd1, 4'd1, 1'b0}); // backed out
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 4'd1, 4'd1, 1'b1}); // A1
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 4'd1, 4'd1, 1'b1}); // AB
    tbl.push_back('{1'b1, 1'b0, 1'b0, 10, 4'd1, 4'd1, 1'b1}); // reversal -> A1
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 4'd1, 4'd1, 1'b0}); // out, no count
    tbl.push_back('{1'b0, 1'b0, 1'b1,  2, 4'd0, 4'd0, 1'b0}); // clear

    // Reset state
    Reset = 1'b1; sens_a = 1'b1; sens_b = 1'b1; clear = 1'b1;
    step(3);
    chk("rst_a2b",   Count_a2b, 0);
    chk("rst_b2a",   Count_b2a, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fault", fault, 0);
    do_reset();

    // Table-driven sequences
    f0 = fault_cnt;
    for (int i = 0; i < tbl.size(); i++) begin
      sens_a = tbl[i].a; sens_b = tbl[i].b; clear = tbl[i].clr;
      step(tbl[i].cyc);
      clear = 1'b0;
      chk($sformatf("vec%0d_a2b", i),  Count_a2b, tbl[i].e_a2b);
      chk($sformatf("vec%0d_b2a", i),  Count_b2a, tbl[i].e_b2a);
      chk($sformatf("vec%0d_busy", i), busy,      tbl[i].e_busy);
    end
    chk("tbl_no_fault", fault_cnt - f0, 0);

    // Latency: count changes exactly 7 cycles after raw b falls
    do_reset();
    f0 = fault_cnt;
    sens_a = 1'b1; step(10);
    sens_b = 1'b1; step(10);
    sens_a = 1'b0; step(10);
    sens_b = 1'b0; step(6);
    chk("lat_before", Count_a2b, 0);
    step(1);
    chk("lat_at7", Count_a2b, 1);
    chk("lat_b2a", Count_b2a, 0);
    step(5);
    chk("lat_no_fault", fault_cnt - f0, 0);

    // Four B->A, fifth with clear on its increment edge
    do_reset();
    repeat (4) ba_bogey();
    chk("ba4", Count_b2a, 4);
    sens_b = 1'b1; step(10);
    sens_a = 1'b1; step(10);
    sens_b = 1'b0; step(10);
    sens_a = 1'b0; step(6);
    chk("ba5_pre", Count_b2a, 4);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("ba5_clr", Count_b2a, 0);
    step(5);
    chk("ba5_hold", Count_b2a, 0);
    chk("ba5_busy", busy, 0);

    // Saturation
    do_reset();
    repeat (15) ab_bogey();
    chk("sat15", Count_a2b, 15);
    ab_bogey();
    chk("sat16", Count_a2b, 15);
    chk("sat_b2a", Count_b2a, 0);

    // Chatter on sens_a never gets through the filter
    do_reset();
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sens_a = ~sens_a;
      step(1);
      busy_seen |= busy;
    end
    sens_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      busy_seen |= busy;
    end
    chk("chat_busy", busy_seen, 0);
    chk("chat_a2b", Count_a2b, 0);
    chk("chat_b2a", Count_b2a, 0);

    // Simultaneous rise: one fault, WAIT until both low
    f0 = fault_cnt;
    sens_a = 1'b1; sens_b = 1'b1; step(20);
    chk("sim_fault", fault_cnt - f0, 1);
    chk("sim_busy", busy, 1);
    sens_a = 1'b0; step(10);
    chk("sim_wait_busy", busy, 1);
    sens_a = 1'b1; sens_b = 1'b0; step(10);
    chk("sim_wait_busy2", busy, 1);
    sens_a = 1'b0; step(10);
    chk("sim_idle", busy, 0);
    chk("sim_a2b", Count_a2b, 0);
    chk("sim_b2a", Count_b2a, 0);
    chk("sim_fault_once", fault_cnt - f0, 1);

    // Timeout with sens_a stuck high
    do_reset();
    f0 = fault_cnt;
    sens_a = 1'b1; step(TMO + 20);
    chk("tmo_fault", fault_cnt - f0, 1);
    chk("tmo_busy", busy, 1);
    sens_a = 1'b0; step(5);
    chk("tmo_busy_hold", busy, 1);
    step(2);
    chk("tmo_release", busy, 0);
    chk("tmo_a2b", Count_a2b, 0);
    chk("tmo_b2a", Count_b2a, 0);
    chk("tmo_fault_once", fault_cnt - f0, 1);

    // Reset mid-sequence discards partial bogey and zeros counts
    ab_bogey();
    chk("mid_pre", Count_a2b, 1);
    sens_a = 1'b1; step(10);
    sens_b = 1'b1; step(10);
    Reset = 1'b1; clear = 1'b0; sens_b = 1'b0;
    step(1);
    chk("mid_a2b", Count_a2b, 0);
    chk("mid_busy", busy, 0);
    chk("mid_fault", fault, 0);
    step(2);
    Reset = 1'b0;
    step(6);
    chk("mid_refilter_pre", busy, 0);
    step(1);
    chk("mid_refilter", busy, 1);
    sens_a = 1'b0; step(10);
    chk("mid_idle", busy, 0);
    chk("mid_cnt", Count_a2b, 0);

    chk("fault_width", fault_dbl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
